// File: rtl/c2h_source_arbiter_pkg.sv
// c2h_arb_pkg: shared state encoding and widths for the C2H source arbiter
package c2h_arb_pkg;
  typedef enum logic [1:0] {IDLE, OFFER, DRAIN} state_t;
  localparam int N_SRC_DEF = 4;
  localparam int SRC_ID_W = $clog2(N_SRC_DEF);
  localparam int CNT_W = 16;
  function automatic int id_w(input int n);
    return n < 2 ? 1 : $clog2(n);
  endfunction
endpackage

// File: rtl/c2h_source_arbiter_if.sv
// c2h_source_arbiter_if: source request/ack bundle plus the packer record handshake
interface c2h_source_arbiter_if import c2h_arb_pkg::*; #(
  parameter int N_SRC = 4,
  parameter int DATA_WIDTH = 4064
);
  localparam int IDW = id_w(N_SRC);
  logic [N_SRC-1:0] src_valid;
  logic [N_SRC*DATA_WIDTH-1:0] src_data;
  logic [N_SRC-1:0] src_ack;
  logic pkt_data_valid;
  logic [DATA_WIDTH-1:0] pkt_data;
  logic pkt_data_next;
  logic [IDW-1:0] pkt_src_id;
  modport master (
    input src_valid, src_data, pkt_data_next,
    output src_ack, pkt_data_valid, pkt_data, pkt_src_id
  );
  modport slave (
    output src_valid, src_data, pkt_data_next,
    input src_ack, pkt_data_valid, pkt_data, pkt_src_id
  );
endinterface

// File: rtl/c2h_source_arbiter_rr_pick.sv
// c2h_rr_pick: rotate-priority encoder, first requester after last_grant wins
module c2h_rr_pick import c2h_arb_pkg::*; #(
  parameter int N_SRC = 4,
  parameter int IDW = id_w(N_SRC)
) (
  input  logic [N_SRC-1:0] req,
  input  logic [IDW-1:0]   last_grant,
  output logic [IDW-1:0]   win,
  output logic             any
);
  always_comb begin
    logic [IDW-1:0] k;
    k = '0;
    win = '0;
    any = |req;
    // walk from farthest to nearest so the nearest requester overwrites last
    for (int i = N_SRC - 1; i >= 0; i--) begin
      k = IDW'((int'(last_grant) + 1 + i) % N_SRC);
      if (req[k]) win = k;
    end
  end
endmodule

// File: rtl/c2h_source_arbiter.sv
// c2h_source_arbiter: round-robin share of the C2H packet packer between N_SRC producers
module c2h_source_arbiter import c2h_arb_pkg::*; #(
  parameter int N_SRC = 4,
  parameter int DATA_WIDTH = 4064,
  parameter int TIMEOUT = 64
) (
  input  logic                 m_axis_c2h_aclk,
  input  logic                 m_axis_c2h_aresetn,
  input  logic                 arb_en,
  c2h_source_arbiter_if.master bus,
  output logic                 busy,
  output logic                 timeout_err,
  output logic [CNT_W-1:0]     pkt_count
);
  localparam int IDW = id_w(N_SRC);
  localparam int WDW = $clog2(TIMEOUT + 1);
  state_t state, state_n;
  logic [IDW-1:0] last_grant, win;
  logic [WDW-1:0] wd;
  logic any, grant, take, tmo, done;
  c2h_rr_pick #(.N_SRC(N_SRC), .IDW(IDW)) u_pick (
    .req(bus.src_valid),
    .last_grant(last_grant),
    .win(win),
    .any(any)
  );
  always_comb begin
    grant = state == IDLE && arb_en && bus.pkt_data_next && any;
    take = state == OFFER && !bus.pkt_data_next;
    tmo = state == OFFER && bus.pkt_data_next && wd == WDW'(TIMEOUT - 1);
    done = state == DRAIN && bus.pkt_data_next;
    state_n = grant ? OFFER : take ? DRAIN : (tmo || done) ? IDLE : state;
    busy = state != IDLE;
  end
  always_ff @(posedge m_axis_c2h_aclk or negedge m_axis_c2h_aresetn)
    if (!m_axis_c2h_aresetn) state <= IDLE;
    else state <= state_n;
  always_ff @(posedge m_axis_c2h_aclk or negedge m_axis_c2h_aresetn) begin
    if (!m_axis_c2h_aresetn) begin
      last_grant <= IDW'(N_SRC - 1);
      bus.pkt_src_id <= '0;
      bus.pkt_data <= '0;
      bus.pkt_data_valid <= 1'b0;
      bus.src_ack <= '0;
      wd <= '0;
      timeout_err <= 1'b0;
      pkt_count <= '0;
    end else begin
      bus.src_ack <= take ? N_SRC'(1) << bus.pkt_src_id : '0;
      bus.pkt_data_valid <= grant ? 1'b1 : (take || tmo) ? 1'b0 : bus.pkt_data_valid;
      if (grant) begin
        bus.pkt_data <= bus.src_data[win*DATA_WIDTH +: DATA_WIDTH];
        bus.pkt_src_id <= win;
        last_grant <= win;
        wd <= '0;
      end else if (state == OFFER) begin
        wd <= wd + 1'b1;
      end
      // a timed-out source keeps requesting; its round-robin slot is already spent
      if (tmo) timeout_err <= 1'b1;
      if (done) pkt_count <= pkt_count + 1'b1;
    end
  end
endmodule

// File: doc/c2h_source_arbiter.md
# c2h_source_arbiter

Round-robin scheduler that shares the single AXIS C2H packet packer between up to N_SRC independent data producers. It selects one pending source at a time, holds that source's DATA_WIDTH-bit record stable on the packer's `data`/`data_valid` inputs, and tracks the packer's `data_next` handshake through acceptance and completion. It acknowledges the source once the packer has taken the record. It sits directly in front of the packer in the `m_axis_c2h_aclk` domain.

## Interface
- `N_SRC`, 4: number of requesting sources (2..8).
- `DATA_WIDTH`, 4064: record width. Must match the packer.
- `TIMEOUT`, 64: maximum cycles in OFFER before the attempt is abandoned.
- `m_axis_c2h_aclk` in 1: the only clock.
- `m_axis_c2h_aresetn` in 1: asynchronous, active-low reset.
- `arb_en` in 1: when 0, no new grants are issued; any transfer in flight completes normally.
- `src_valid` in N_SRC: per-source request.
- `src_data` in N_SRC*DATA_WIDTH: source i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- `src_ack` out N_SRC: one-cycle pulse to the source whose record the packer accepted.
- `pkt_data_valid` out 1: drives the packer's `data_valid`.
- `pkt_data` out DATA_WIDTH: drives the packer's `data`. Registered copy of the granted record.
- `pkt_data_next` in 1: the packer's `data_next`. 1 = packer idle/ready; it falls when the packer takes the record and rises when the packet is finished.
- `pkt_src_id` out $clog2(N_SRC): index of the current/last granted source.
- `busy` out 1: high whenever state ≠ IDLE.
- `timeout_err` out 1: sticky; set on an OFFER timeout and cleared only by reset.
- `pkt_count` out 16: completed packets. Wraps from 0xFFFF to 0.

## Operation
- Source contract: a source holds `src_valid` high and `src_data` stable until it receives `src_ack`. Data is sampled only at grant.
- Round-robin order: priority starts at `last_grant+1` mod N_SRC. `last_grant` resets to N_SRC-1, so source 0 wins first after reset. `last_grant` updates at the moment of grant.
- IDLE:
  - Grant condition: `arb_en` & `pkt_data_next` & |`src_valid`.
  - On grant: latch the winner's data into `pkt_data`, the winner's index into `pkt_src_id`, set `pkt_data_valid`=1, clear the watchdog, and go to OFFER.
- OFFER:
  - Hold `pkt_data_valid`=1 and keep `pkt_data` frozen.
  - On `pkt_data_next`==0: set `pkt_data_valid`=0, pulse `src_ack[pkt_src_id]` for one cycle, and go to DRAIN.
  - Otherwise the watchdog increments. When it reaches TIMEOUT-1: set `timeout_err`, set `pkt_data_valid`=0, return to IDLE with no ack. The source stays pending and is re-arbitrated; its priority slot is already consumed.
- DRAIN: wait for `pkt_data_next`==1, then increment `pkt_count` and go to IDLE.
- Simultaneous events:
  - A `src_valid` rising during OFFER or DRAIN is queued; it is served by the next IDLE arbitration.
  - `arb_en` falling during OFFER or DRAIN has no effect on the current transfer.
- Reset mid-operation: all state clears immediately. No ack is issued, and sources must re-request.

## Timing
- Reset values: `src_ack`=0, `pkt_data_valid`=0, `pkt_data`=0, `pkt_src_id`=0, `busy`=0, `timeout_err`=0, `pkt_count`=0. State is IDLE.
- Grant latency: 1 cycle from a sampled `src_valid` to `pkt_data_valid`/`pkt_data`.
- Ack timing: `src_ack` asserts in the cycle after `pkt_data_next` is sampled low in OFFER, together with `pkt_data_valid` falling.
- Minimum spacing between grants: DRAIN→IDLE takes one cycle, and IDLE evaluates its grant one cycle later.
- `pkt_data` stays unchanged from grant until the next grant, so the packer may sample it at any point in OFFER.

## Structure
- Package `c2h_arb_pkg`: the state enum (IDLE, OFFER, DRAIN), `SRC_ID_W = $clog2(N_SRC)`, and the `pkt_count` width constant.
- Sub-module `c2h_rr_pick`: combinational rotate-priority encoder. Inputs: request vector, `last_grant`. Outputs: winner index and `any`.

## Test plan
- Single source: source 2 requests with data 0xA5 pattern; packer model drops `data_next` after 4 cycles and raises it 10 cycles later. Required: `pkt_src_id`=2, one `src_ack[2]` pulse, `pkt_count`=1, and the record matches bit-exactly.
- All 4 sources request continuously for 8 packets. Required: grant order 0,1,2,3,0,1,2,3 and exactly 8 acks.
- Packer model never drops `data_next`. Required: `pkt_data_valid` falls after 64 cycles, `timeout_err`=1, no ack, and the request is re-granted afterwards.
- `arb_en`=0 with requests pending. Required: no grant. Clear `arb_en` mid-DRAIN: that packet completes and no further grant is issued.
- Assert reset in OFFER. Required: all outputs return to their reset values within the reset assertion, and source 0 is granted first after release.
- Run 65 536 packets. Required: `pkt_count` wraps to 0.
